// File: rtl/hue_pkg.sv
// hue_pkg: shared types and helpers for the RGB hue-wheel sequencer.
//   phase_t      - six-phase hue wheel encoding (6 and 7 are illegal)
//   NUM_PHASES   - number of legal phases
//   phase_next() - cyclic successor; illegal encodings recover to GREEN_INC
package hue_pkg;

  localparam int NUM_PHASES = 6;

  typedef enum logic [2:0] {
    GREEN_INC = 3'd0,
    RED_DEC   = 3'd1,
    BLUE_INC  = 3'd2,
    GREEN_DEC = 3'd3,
    RED_INC   = 3'd4,
    BLUE_DEC  = 3'd5
  } phase_t;

  function automatic phase_t phase_next(input phase_t p);
    case (p)
      GREEN_INC: return RED_DEC;
      RED_DEC:   return BLUE_INC;
      BLUE_INC:  return GREEN_DEC;
      GREEN_DEC: return RED_INC;
      RED_INC:   return BLUE_DEC;
      default:   return GREEN_INC;
    endcase
  endfunction

endpackage

// File: rtl/hue_sequencer_step_timer.sv
// step_timer: free-running terminal counter, counts 0..STEP_CLKS-1 while en.
//   clk  - system clock
//   rst  - synchronous active-high reset, count returns to 0
//   en   - count enable; 0 holds the count
//   tick - high during the terminal-count cycle (only while en)
module step_timer #(
  parameter int STEP_CLKS = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CLKS - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/hue_sequencer.sv
// hue_sequencer: steps a six-phase RGB hue wheel with linear ramps and
// produces the three PWM duty values. A new duty set is only committed on
// period_wrap, so a PWM period never sees a mid-period duty change.
//   clk, rst              - clock, synchronous active-high reset
//   en                    - run enable; 0 freezes all state
//   period_wrap           - pulse on the PWM counter's last count
//   duty_r/duty_g/duty_b  - registered duty values (0..PWM_INTERVAL)
//   phase                 - current hue phase
//   phase_adv             - one-cycle pulse when phase changes
//
// phase      | meaning
// GREEN_INC  | R=MAX,       G=level,     B=0
// RED_DEC    | R=MAX-level, G=MAX,       B=0
// BLUE_INC   | R=0,         G=MAX,       B=level
// GREEN_DEC  | R=0,         G=MAX-level, B=MAX
// RED_INC    | R=level,     G=0,         B=MAX
// BLUE_DEC   | R=MAX,       G=0,         B=MAX-level
module hue_sequencer
  import hue_pkg::*;
#(
  parameter  int PWM_INTERVAL = 1000,
  parameter  int STEP_SIZE    = 10,
  parameter  int STEP_CLKS    = 20000,
  localparam int W            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         period_wrap,
  output logic [W-1:0] duty_r,
  output logic [W-1:0] duty_g,
  output logic [W-1:0] duty_b,
  output logic [2:0]   phase,
  output logic         phase_adv
);

  localparam logic [W-1:0] MAX_W  = W'(PWM_INTERVAL);
  localparam logic [W:0]   MAX_X  = (W + 1)'(PWM_INTERVAL);
  localparam logic [W:0]   STEP_X = (W + 1)'(STEP_SIZE);

  logic         tick;
  logic         commit;
  logic         pending_q;
  phase_t       phase_q, phase_nx;
  logic [W-1:0] level_q, level_nx;
  logic [W:0]   level_sum;
  logic         adv_nx;
  logic [W-1:0] inv;
  logic [W-1:0] r_nx, g_nx, b_nx;

  step_timer #(.STEP_CLKS(STEP_CLKS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // A tick coinciding with the wrap commits directly instead of via pending.
  assign commit    = en && period_wrap && (pending_q || tick);
  assign level_sum = {1'b0, level_q} + STEP_X;
  assign phase     = phase_q;

  always_comb begin
    phase_nx = phase_q;
    level_nx = level_sum[W-1:0];
    adv_nx   = 1'b0;
    if (phase_q > BLUE_DEC) begin
      phase_nx = GREEN_INC;
      level_nx = '0;
      adv_nx   = 1'b1;
    end else if (level_sum >= MAX_X) begin
      phase_nx = phase_next(phase_q);
      level_nx = '0;
      adv_nx   = 1'b1;
    end
  end

  // Duty decode from the post-commit phase/level; level never exceeds MAX.
  always_comb begin
    inv  = MAX_W - level_nx;
    r_nx = MAX_W;
    g_nx = '0;
    b_nx = '0;
    case (phase_nx)
      GREEN_INC: begin r_nx = MAX_W;    g_nx = level_nx; b_nx = '0;       end
      RED_DEC:   begin r_nx = inv;      g_nx = MAX_W;    b_nx = '0;       end
      BLUE_INC:  begin r_nx = '0;       g_nx = MAX_W;    b_nx = level_nx; end
      GREEN_DEC: begin r_nx = '0;       g_nx = inv;      b_nx = MAX_W;    end
      RED_INC:   begin r_nx = level_nx; g_nx = '0;       b_nx = MAX_W;    end
      BLUE_DEC:  begin r_nx = MAX_W;    g_nx = '0;       b_nx = inv;      end
      default:   begin r_nx = MAX_W;    g_nx = '0;       b_nx = '0;       end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= GREEN_INC;
      level_q   <= '0;
      pending_q <= 1'b0;
      duty_r    <= MAX_W;
      duty_g    <= '0;
      duty_b    <= '0;
      phase_adv <= 1'b0;
    end else begin
      phase_adv <= 1'b0;
      if (commit) begin
        pending_q <= 1'b0;
        phase_q   <= phase_nx;
        level_q   <= level_nx;
        phase_adv <= adv_nx;
        duty_r    <= r_nx;
        duty_g    <= g_nx;
        duty_b    <= b_nx;
      end else if (tick) begin
        // One deep: a tick while already pending is simply absorbed.
        pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hue_sequencer.sv
module tb_hue_sequencer;
  import hue_pkg::*;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         period_wrap;
  logic [W-1:0] duty_r, duty_g, duty_b;
  logic [2:0]   phase;
  logic         phase_adv;

  int checks   = 0;
  int failures = 0;
  int wc       = 0;
  int adv_cnt  = 0;

  always #5 clk = ~clk;

  hue_sequencer #(
    .PWM_INTERVAL (100),
    .STEP_SIZE    (25),
    .STEP_CLKS    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period_wrap (period_wrap),
    .duty_r      (duty_r),
    .duty_g      (duty_g),
    .duty_b      (duty_b),
    .phase       (phase),
    .phase_adv   (phase_adv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_duty(input string tag, input int r, input int g, input int b);
    chk({tag, "_r"}, 32'(duty_r), r);
    chk({tag, "_g"}, 32'(duty_g), g);
    chk({tag, "_b"}, 32'(duty_b), b);
  endtask

  task automatic edge1(input logic w);
    period_wrap = w;
    @(posedge clk);
    #1;
    if (phase_adv === 1'b1) adv_cnt++;
  endtask

  // Free-running wraps on every 4th clock, aligned so a wrap meets each tick.
  task automatic run_wc(input int n);
    for (int i = 0; i < n; i++) begin
      edge1(wc % 4 == 3);
      wc++;
    end
  endtask

  function automatic void exp_duty(input int ph, input int lv, output int r, output int g, output int b);
    case (ph)
      0: begin r = 100;      g = lv;       b = 0;        end
      1: begin r = 100 - lv; g = 100;      b = 0;        end
      2: begin r = 0;        g = 100;      b = lv;       end
      3: begin r = 0;        g = 100 - lv; b = 100;      end
      4: begin r = lv;       g = 0;        b = 100;      end
      5: begin r = 100;      g = 0;        b = 100 - lv; end
      default: begin r = 100; g = 0; b = 0; end
    endcase
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  initial begin
    int er, eg, eb, pr, pg, pb, bad;

    // Reset
    rst = 1'b1; en = 1'b0; period_wrap = 1'b0;
    edge1(1'b0);
    edge1(1'b0);
    chk_duty("rst", 100, 0, 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_adv", 32'(phase_adv), 0);
    chk("rst_pend", 32'(dut.pending_q), 0);

    rst = 1'b0; en = 1'b1; wc = 0; adv_cnt = 0;

    // First commit lands exactly on the tick/wrap coincidence at clock 8
    run_wc(7);
    chk_duty("pre_commit1", 100, 0, 0);
    run_wc(1);
    chk_duty("commit1", 100, 25, 0);
    chk("commit1_pend", 32'(dut.pending_q), 0);

    // Full wheel: 24 commits total
    pr = 100; pg = 25; pb = 0;
    for (int n = 2; n <= 24; n++) begin
      run_wc(8);
      exp_duty((n / 4) % 6, (n % 4) * 25, er, eg, eb);
      chk("wheel_phase", 32'(phase), (n / 4) % 6);
      chk_duty("wheel", er, eg, eb);
      chk("wheel_adv", 32'(phase_adv), (n % 4 == 0) ? 1 : 0);
      chk("wheel_jump", ((absdiff(int'(duty_r), pr) <= 25) && (absdiff(int'(duty_g), pg) <= 25) &&
                         (absdiff(int'(duty_b), pb) <= 25)) ? 1 : 0, 1);
      pr = int'(duty_r); pg = int'(duty_g); pb = int'(duty_b);
      if (n == 4) chk("adv_once", adv_cnt, 1);
    end
    chk("adv_total", adv_cnt, 6);
    chk_duty("wheel_end", 100, 0, 0);
    chk("coinc_pend", 32'(dut.pending_q), 0);

    // Two ticks with no wrap -> only one pending step
    for (int i = 0; i < 20; i++) edge1(1'b0);
    chk_duty("nowrap_hold", 100, 0, 0);
    chk("nowrap_pend", 32'(dut.pending_q), 1);
    edge1(1'b1);
    chk_duty("pend_commit", 100, 25, 0);
    chk("pend_clear", 32'(dut.pending_q), 0);
    edge1(1'b0);
    chk_duty("single_step", 100, 25, 0);

    // Freeze with wraps active; timer sits at 6
    en = 1'b0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      edge1(i % 4 == 3);
      if (duty_r !== 7'd100 || duty_g !== 7'd25 || duty_b !== 7'd0 || phase !== 3'd0 || phase_adv !== 1'b0)
        bad++;
    end
    chk("freeze_outputs", bad, 0);
    chk("freeze_pend", 32'(dut.pending_q), 0);
    en = 1'b1;
    edge1(1'b0);
    chk("resume_pend0", 32'(dut.pending_q), 0);
    edge1(1'b0);
    chk("resume_pend1", 32'(dut.pending_q), 1);
    chk_duty("resume_hold", 100, 25, 0);

    // Reach phase 3 with pending set, then reset with en and wrap high
    rst = 1'b1;
    edge1(1'b0);
    rst = 1'b0; wc = 0;
    run_wc(96);
    chk("ph3_phase", 32'(phase), 3);
    chk_duty("ph3", 0, 100, 100);
    for (int i = 0; i < 8; i++) edge1(1'b0);
    chk("ph3_pend", 32'(dut.pending_q), 1);
    rst = 1'b1;
    edge1(1'b1);
    chk_duty("midrst", 100, 0, 0);
    chk("midrst_phase", 32'(phase), 0);
    chk("midrst_adv", 32'(phase_adv), 0);
    chk("midrst_pend", 32'(dut.pending_q), 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) edge1(1'b1);
    chk_duty("post_rst_wait", 100, 0, 0);
    edge1(1'b1);
    chk_duty("post_rst_commit", 100, 25, 0);

    // Illegal phase recovers on the next commit
    force dut.phase_q = phase_t'(3'd6);
    #1;
    release dut.phase_q;
    chk("illegal_set", 32'(phase), 6);
    for (int i = 0; i < 7; i++) edge1(1'b0);
    edge1(1'b1);
    chk("illegal_phase", 32'(phase), 0);
    chk("illegal_level", 32'(dut.level_q), 0);
    chk_duty("illegal", 100, 0, 0);
    for (int i = 0; i < 7; i++) edge1(1'b0);
    edge1(1'b1);
    chk_duty("illegal_next", 100, 25, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
